// File: rtl/instruction_fetch_queue_pkg.sv
// Shared fetch-path widths; must match the instruction ROM and MiniAlu decode.
package instruction_fetch_queue_pkg;

    localparam int IFQ_ADDR_W  = 16;
    localparam int IFQ_INSTR_W = 28;
    localparam int IFQ_DEPTH   = 4;

    localparam logic [IFQ_ADDR_W-1:0] RESET_VECTOR = '0;

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Fetch queue bus: ROM port, fetch/redirect control, and decode valid/ready.
interface instruction_fetch_queue_if
    import instruction_fetch_queue_pkg::*;
#(
    parameter int ADDR_W  = IFQ_ADDR_W,
    parameter int INSTR_W = IFQ_INSTR_W
);
    logic [ADDR_W-1:0]  oRomAddress;
    logic [INSTR_W-1:0] iRomInstruction;
    logic               iFetchEnable;
    logic               iBranchTaken;
    logic [ADDR_W-1:0]  iBranchTarget;
    logic [INSTR_W-1:0] oInstruction;
    logic [ADDR_W-1:0]  oInstrAddress;
    logic               oValid;
    logic               iReady;
    logic               oFull;
    logic               oEmpty;

    modport master (
        output oRomAddress, oInstruction, oInstrAddress, oValid, oFull, oEmpty,
        input  iRomInstruction, iFetchEnable, iBranchTaken, iBranchTarget, iReady
    );

    modport slave (
        input  oRomAddress, oInstruction, oInstrAddress, oValid, oFull, oEmpty,
        output iRomInstruction, iFetchEnable, iBranchTaken, iBranchTarget, iReady
    );

endinterface

// File: rtl/instruction_fetch_queue_fetch_fifo_flush.sv
// Circular FIFO with synchronous flush; head data is combinational from storage.
// Flush wins over push/pop in the same cycle; storage itself is never reset.
module fetch_fifo_flush #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 44
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          push_dat_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          head_dat_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + 1'b1;
            if (pop_i)  head_d = head_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[tail_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[head_q];
    assign count_o    = count_q;
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: owns the PC, pushes {PC, ROM word} into a small queue for decode.
// A taken branch flushes the queue and redirects the PC, taking priority over push/pop.
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int DEPTH   = IFQ_DEPTH,
    parameter int ADDR_W  = IFQ_ADDR_W,
    parameter int INSTR_W = IFQ_INSTR_W
) (
    input  logic                  Clock,
    input  logic                  Reset,
    instruction_fetch_queue_if.master bus
);
    localparam int DATA_W = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0]         pc_q, pc_d;
    logic [DATA_W-1:0]         head_dat;
    logic [$clog2(DEPTH):0]    count;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      valid;
    logic                      pop;
    logic                      push;

    // oValid is masked by the redirect so decode never consumes a doomed entry.
    assign valid = !fifo_empty && !bus.iBranchTaken;
    assign pop   = valid && bus.iReady;
    assign push  = bus.iFetchEnable && !bus.iBranchTaken && (!fifo_full || pop);

    always_comb begin
        pc_d = pc_q;
        if (bus.iBranchTaken) pc_d = bus.iBranchTarget;
        else if (push)        pc_d = pc_q + 1'b1;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) pc_q <= ADDR_W'(RESET_VECTOR);
        else        pc_q <= pc_d;
    end

    fetch_fifo_flush #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (Clock),
        .rst_n      (Reset),
        .flush_i    (bus.iBranchTaken),
        .push_i     (push),
        .push_dat_i ({pc_q, bus.iRomInstruction}),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .count_o    (count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign bus.oRomAddress   = pc_q;
    assign bus.oInstrAddress = head_dat[DATA_W-1:INSTR_W];
    assign bus.oInstruction  = head_dat[INSTR_W-1:0];
    assign bus.oValid        = valid;
    assign bus.oFull         = fifo_full;
    assign bus.oEmpty        = fifo_empty;

    logic unused_count;
    assign unused_count = ^count;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue; ROM model returns addr + 0x1000000.
module tb_instruction_fetch_queue;
    import instruction_fetch_queue_pkg::*;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    instruction_fetch_queue_if #(.ADDR_W(16), .INSTR_W(28)) bus ();

    instruction_fetch_queue #(.DEPTH(4), .ADDR_W(16), .INSTR_W(28)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    assign bus.iRomInstruction = 28'h1000000 + {12'h000, bus.oRomAddress};

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [15:0] addr);
        chk({tag, "_valid"}, 32'(bus.oValid), 32'd1);
        chk({tag, "_addr"}, 32'(bus.oInstrAddress), 32'(addr));
        chk({tag, "_instr"}, 32'(bus.oInstruction), 32'h1000000 + 32'(addr));
    endtask

    initial begin
        bus.iFetchEnable  = 1'b1;
        bus.iReady        = 1'b1;
        bus.iBranchTaken  = 1'b0;
        bus.iBranchTarget = 16'h0000;

        // Reset held for three edges
        tick(); tick(); tick();
        chk("rst_romaddr", 32'(bus.oRomAddress), 32'h0);
        chk("rst_valid",   32'(bus.oValid), 32'd0);
        chk("rst_empty",   32'(bus.oEmpty), 32'd1);
        chk("rst_full",    32'(bus.oFull), 32'd0);

        // Streaming with iReady=1: one instruction per cycle
        Reset = 1'b1;
        #1;
        chk("rel_valid", 32'(bus.oValid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_head("stream", 16'(i));
        end
        chk("stream_pc", 32'(bus.oRomAddress), 32'h4);

        // Backpressure from release: fills in four edges, PC holds at 4
        Reset = 1'b0;
        #1;
        chk("rst2_valid", 32'(bus.oValid), 32'd0);
        bus.iReady = 1'b0;
        Reset = 1'b1;
        tick(); tick(); tick();
        chk("bp3_full", 32'(bus.oFull), 32'd0);
        tick();
        chk("bp4_full", 32'(bus.oFull), 32'd1);
        chk("bp4_pc",   32'(bus.oRomAddress), 32'h4);
        chk_head("bp4_head", 16'h0000);
        tick();
        chk("bp5_pc", 32'(bus.oRomAddress), 32'h4);
        chk_head("bp5_head", 16'h0000);
        bus.iReady = 1'b1;
        tick();
        chk_head("bp_popfull", 16'h0001);
        chk("bp_popfull_full", 32'(bus.oFull), 32'd1);
        chk("bp_popfull_pc",   32'(bus.oRomAddress), 32'h5);

        // Fetch disabled: queue (1..4 minus head) drains, PC frozen
        bus.iFetchEnable = 1'b0;
        tick(); chk_head("drain_a", 16'h0002);
        tick(); chk_head("drain_b", 16'h0003);
        tick(); chk_head("drain_c", 16'h0004);
        tick();
        chk("drain_empty", 32'(bus.oEmpty), 32'd1);
        chk("drain_valid", 32'(bus.oValid), 32'd0);
        chk("drain_pc",    32'(bus.oRomAddress), 32'h5);

        // Queue addrs 5..7, then redirect to 0x0020
        bus.iFetchEnable = 1'b1;
        bus.iReady = 1'b0;
        tick(); tick(); tick();
        chk_head("fill567", 16'h0005);
        chk("fill567_pc", 32'(bus.oRomAddress), 32'h8);
        bus.iReady = 1'b1;
        bus.iBranchTaken = 1'b1;
        bus.iBranchTarget = 16'h0020;
        #1;
        chk("br_valid_low", 32'(bus.oValid), 32'd0);
        tick();
        bus.iBranchTaken = 1'b0;
        #1;
        chk("br_empty", 32'(bus.oEmpty), 32'd1);
        chk("br_valid", 32'(bus.oValid), 32'd0);
        chk("br_pc",    32'(bus.oRomAddress), 32'h20);
        tick(); chk_head("br_tgt",  16'h0020);
        tick(); chk_head("br_next", 16'h0021);

        // Redirect near top of address space: PC wraps silently
        bus.iBranchTaken = 1'b1;
        bus.iBranchTarget = 16'hFFFE;
        tick();
        bus.iBranchTaken = 1'b0;
        tick(); chk_head("wrap_a", 16'hFFFE);
        tick(); chk_head("wrap_b", 16'hFFFF);
        tick(); chk_head("wrap_c", 16'h0000);
        chk("wrap_pc", 32'(bus.oRomAddress), 32'h1);

        // Asynchronous reset between edges
        #2;
        Reset = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.oValid), 32'd0);
        chk("arst_empty", 32'(bus.oEmpty), 32'd1);
        chk("arst_pc",    32'(bus.oRomAddress), 32'h0);
        tick();
        Reset = 1'b1;
        tick();
        chk_head("arst_restart", 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
